// File: rtl/axi_helper_pkg.sv
// rtl/axi_helper_pkg.sv - response codes and FSM state types for the AXI-Lite subordinate
package axi_helper;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/sub_mem.sv
// rtl/sub_mem.sv - 1W/1R synchronous word array, registered read, read-before-write
module sub_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Same-edge read of a written word sees the previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_sub_mem.sv
// rtl/axi_sub_mem.sv - AXI4-Lite single-beat subordinate backed by a local word memory
module axi_sub_mem
  import axi_helper::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Full-width compare so high address bits never alias into the array.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(MEM_DEPTH);
  endfunction

  wr_state_t         wr_state, wr_state_d;
  rd_state_t         rd_state, rd_state_d;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  resp_t             bresp_q, rresp_q;
  logic              rd_ok_q;
  logic              aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, mem_q;

  assign AWREADY = (wr_state == WR_IDLE) && !aw_got;
  assign WREADY  = (wr_state == WR_IDLE) && !w_got;
  assign BVALID  = (wr_state == WR_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = (rd_state == RD_IDLE);
  assign RVALID  = (rd_state == RD_DATA);
  assign RRESP   = rresp_q;
  assign RDATA   = rd_ok_q ? mem_q : '0;

  always_comb begin
    aw_hs      = AWVALID && AWREADY;
    w_hs       = WVALID && WREADY;
    ar_hs      = ARVALID && ARREADY;
    // Bypass the capture registers so the edge delivering the second half commits.
    wr_addr    = aw_got ? awaddr_q : AWADDR;
    wr_data    = w_got ? wdata_q : WDATA;
    commit     = (wr_state == WR_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    wr_ok      = in_range(wr_addr);
    wr_state_d = wr_state;
    rd_state_d = rd_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_state_d = WR_RESP;
      WR_RESP: if (BREADY) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_state_d = RD_DATA;
      RD_DATA: if (RREADY) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      wr_state <= wr_state_d;
      if (aw_hs) begin
        awaddr_q <= AWADDR;
        aw_got   <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= WDATA;
        w_got   <= 1'b1;
      end
      if (commit) bresp_q <= wr_ok ? OKAY : DECERR;
      if (wr_state == WR_RESP && BREADY) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      rresp_q  <= OKAY;
      rd_ok_q  <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      if (ar_hs) begin
        rresp_q <= in_range(ARADDR) ? OKAY : DECERR;
        rd_ok_q <= in_range(ARADDR);
      end
    end
  end

  sub_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (ACLK),
    .we    (commit && wr_ok),
    .waddr (wr_addr[IDX_W-1:0]),
    .wdata (wr_data),
    .re    (ar_hs),
    .raddr (ARADDR[IDX_W-1:0]),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_axi_sub_mem.sv
// tb/tb_axi_sub_mem.sv - scoreboard bench for the AXI-Lite subordinate memory
module tb_axi_sub_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] DE = 2'b11;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];

  axi_sub_mem #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses on handshake cycles and checks hold under stall.
  logic        b_stall = 1'b0, r_stall = 1'b0;
  logic [1:0]  b_prev, r_prev_resp;
  logic [31:0] r_prev_data;
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        b_stall = 1'b0;
        r_stall = 1'b0;
      end else begin
        if (BVALID && b_stall) chk("bresp_hold", BRESP, b_prev);
        if (BVALID && BREADY) begin
          if (bq.size() == 0) chk("b_unexpected", 1, 0);
          else chk("bresp", BRESP, bq.pop_front());
        end
        b_stall = BVALID && !BREADY;
        b_prev  = BRESP;
        if (RVALID && r_stall) begin
          chk("rdata_hold", RDATA, r_prev_data);
          chk("rresp_hold", RRESP, r_prev_resp);
        end
        if (RVALID && RREADY) begin
          if (rq_data.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            chk("rdata", RDATA, rq_data.pop_front());
            chk("rresp", RRESP, rq_resp.pop_front());
          end
        end
        r_stall     = RVALID && !RREADY;
        r_prev_data = RDATA;
        r_prev_resp = RRESP;
      end
    end
  end

  task automatic drive_aw(input logic [31:0] a);
    int n = 0;
    logic r;
    @(posedge ACLK); #1;
    AWADDR = a; AWVALID = 1'b1;
    do begin @(negedge ACLK); r = AWREADY; @(posedge ACLK); n++; end while (!r && n < 50);
    #1 AWVALID = 1'b0;
    chk("aw_hs", r, 1);
  endtask

  task automatic drive_w(input logic [31:0] d);
    int n = 0;
    logic r;
    @(posedge ACLK); #1;
    WDATA = d; WVALID = 1'b1;
    do begin @(negedge ACLK); r = WREADY; @(posedge ACLK); n++; end while (!r && n < 50);
    #1 WVALID = 1'b0;
    chk("w_hs", r, 1);
  endtask

  task automatic drive_ar(input logic [31:0] a);
    int n = 0;
    logic r;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1'b1;
    do begin @(negedge ACLK); r = ARREADY; @(posedge ACLK); n++; end while (!r && n < 50);
    #1 ARVALID = 1'b0;
    chk("ar_hs", r, 1);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    bq.push_back(resp);
    fork
      drive_aw(a);
      drive_w(d);
    join
    @(negedge ACLK);
    chk("b_latency", BVALID, 1);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    rq_data.push_back(d);
    rq_resp.push_back(resp);
    drive_ar(a);
    @(negedge ACLK);
    chk("r_latency", RVALID, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, OK);
    chk("rst_rresp", RRESP, OK);
    chk("rst_rdata", RDATA, 0);
    @(posedge ACLK); #1 ARESETn = 1'b1;

    // Same-cycle AW/W, then readback
    write_txn(32'h10, 32'hDEADBEEF, OK);
    read_txn(32'h10, 32'hDEADBEEF, OK);

    // W three cycles ahead of AW
    bq.push_back(OK);
    drive_w(32'h12345678);
    repeat (3) begin
      @(negedge ACLK);
      chk("w_lead_wready", WREADY, 0);
      chk("w_lead_bvalid", BVALID, 0);
    end
    drive_aw(32'h20);
    @(negedge ACLK);
    chk("b_latency_wlead", BVALID, 1);
    read_txn(32'h20, 32'h12345678, OK);

    // Decode boundaries
    write_txn(32'h0, 32'h11111111, OK);
    write_txn(32'h3FF, 32'h0BADCAFE, OK);
    write_txn(32'h400, 32'hFFFFFFFF, DE);
    read_txn(32'h0, 32'h11111111, OK);
    read_txn(32'h3FF, 32'h0BADCAFE, OK);
    read_txn(32'h400, 32'h0, DE);
    read_txn(32'h8000_0000, 32'h0, DE);

    // B backpressure
    @(posedge ACLK); #1 BREADY = 1'b0;
    write_txn(32'h30, 32'h55AA55AA, OK);
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_bvalid", BVALID, 1);
      chk("bp_awready", AWREADY, 0);
      chk("bp_wready", WREADY, 0);
    end
    @(posedge ACLK); #1 BREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("bp_b_release", BVALID, 0);
    chk("bp_awready_back", AWREADY, 1);

    // R backpressure
    RREADY = 1'b0;
    read_txn(32'h30, 32'h55AA55AA, OK);
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_rvalid", RVALID, 1);
      chk("bp_arready", ARREADY, 0);
    end
    @(posedge ACLK); #1 RREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("bp_r_release", RVALID, 0);

    // Same-edge commit and read of one word returns old data
    write_txn(32'h5, 32'hA, OK);
    bq.push_back(OK);
    rq_data.push_back(32'hA);
    rq_resp.push_back(OK);
    fork
      drive_aw(32'h5);
      drive_w(32'hB);
      drive_ar(32'h5);
    join
    read_txn(32'h5, 32'hB, OK);

    // Asynchronous reset with both responses pending
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    fork
      drive_aw(32'h50);
      drive_w(32'h77);
      drive_ar(32'h10);
    join
    @(negedge ACLK);
    chk("pre_rst_bvalid", BVALID, 1);
    chk("pre_rst_rvalid", RVALID, 1);
    #1 ARESETn = 1'b0;
    #1;
    chk("async_rst_bvalid", BVALID, 0);
    chk("async_rst_rvalid", RVALID, 0);
    bq.delete();
    rq_data.delete();
    rq_resp.delete();
    @(posedge ACLK); #1 ARESETn = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_wready", WREADY, 1);
    chk("post_rst_arready", ARREADY, 1);
    write_txn(32'h60, 32'hCAFEF00D, OK);
    read_txn(32'h60, 32'hCAFEF00D, OK);

    repeat (3) @(negedge ACLK);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sub_mem.md
Name: axi_sub_mem

Overview:
- AXI4-Lite-style single-beat subordinate. It is the responder end of the manager's AW/W/B/AR/R channels.
- Accepts write address and write data independently, commits the write to a local word-addressed memory, and returns a B response.
- Accepts a read address and returns R data plus a response.
- Sits on the subordinate side of axi4_if and serves as the bench target for the manager.

Parameters:
- DATA_W, 32, data bus width (WDATA/RDATA).
- ADDR_W, 32, address bus width (AWADDR/ARADDR). Addresses are word addresses.
- MEM_DEPTH, 1024, number of DATA_W words. Must be a power of two and ≤ 2^ADDR_W.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWADDR  in  ADDR_W  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response (resp_t).
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_W  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response (resp_t).
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Clock/reset: one clock, ACLK. Reset is asynchronous and active-low on ARESETn.
- Reset values:
  - AWREADY=1, WREADY=1, ARREADY=1.
  - BVALID=0, RVALID=0, BRESP=OKAY, RRESP=OKAY, RDATA=0.
  - Both FSMs return to idle; AW/W capture flags are cleared.
  - Memory contents are not reset.
- Handshake: a transfer occurs on an edge where VALID&&READY. Once asserted, VALID and its payload are held until the handshake; the bench checks this.
- Write FSM (WR_IDLE, WR_RESP):
  - WR_IDLE: AW and W are captured independently.
    - On an AW handshake, latch AWADDR, set aw_got, and drop AWREADY.
    - On a W handshake, latch WDATA, set w_got, and drop WREADY.
    - Both handshakes may occur on the same edge.
  - When aw_got and w_got are both set (including the edge where the second arrives), move to WR_RESP on that edge:
    - If the address is < MEM_DEPTH, write mem[addr] on that edge and set BRESP=OKAY.
    - Otherwise skip the write and set BRESP=DECERR.
    - Assert BVALID.
  - WR_RESP: hold BVALID/BRESP. On the edge with BVALID&&BREADY:
    - Clear BVALID, aw_got and w_got.
    - Set AWREADY=WREADY=1 and return to WR_IDLE.
  - Minimum latency: AW+W handshake edge → BVALID on the next cycle.
- Read FSM (RD_IDLE, RD_DATA):
  - RD_IDLE: on the edge with ARVALID&&ARREADY:
    - Drop ARREADY.
    - Register RDATA=mem[addr] with RRESP=OKAY if addr < MEM_DEPTH; otherwise RDATA=0 with RRESP=DECERR.
    - Assert RVALID and go to RD_DATA.
    - Latency: RVALID is high in the cycle after the AR handshake.
  - RD_DATA: hold RDATA/RRESP/RVALID. On RVALID&&RREADY, clear RVALID, set ARREADY=1 and return to RD_IDLE.
  - Back-to-back reads: the AR cycle after the R handshake is the earliest. There is one outstanding read at most.
- Read and write paths are fully independent and may run concurrently.
- Collision: a write commit and an AR handshake to the same address on the same edge returns the OLD data (read-before-write).
- Address decode uses the full ADDR_W. Any nonzero bit at or above log2(MEM_DEPTH) produces DECERR; addresses are never aliased.
- Reset mid-transaction:
  - Pending B/R responses are dropped and captured AW/W are discarded.
  - A write whose commit edge coincides with reset assertion is not guaranteed.
- Never set EXOKAY or SLVERR.

Decomposition:
- Package axi_helper:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t and rd_state_t enums.
- One sub-module, sub_mem:
  - 1-write/1-read synchronous array of MEM_DEPTH×DATA_W.
  - Registered read port with read-before-write semantics.
  - No reset.
- The FSMs stay in axi_sub_mem.

Test Plan:
1. Reset release, then AW=0x10 and W=0xDEADBEEF on the same cycle with BREADY=1 → BVALID next cycle with BRESP=OKAY. Then AR=0x10 → RVALID one cycle after the handshake, RDATA=0xDEADBEEF, RRESP=OKAY.
2. W=0x12345678 presented 3 cycles before AW=0x20 → WREADY drops after the W handshake, no BVALID until the AW handshake, then BRESP=OKAY. Readback of 0x20 returns 0x12345678.
3. AW=0x400 (=MEM_DEPTH), W=0xFFFFFFFF → BRESP=DECERR and mem[0] is unchanged. AR=0x400 → RDATA=0, RRESP=DECERR.
4. Backpressure: write with BREADY=0 for 5 cycles → BVALID/BRESP held stable and AWREADY/WREADY stay 0; releases on the BREADY=1 edge. The same check applies to R with RREADY low.
5. Collision: mem[5]=0xA, then a write of 0xB to 5 and AR=5 committing on the same edge → RDATA=0xA. A following read returns 0xB.
6. Assert ARESETn=0 while BVALID=1 and RVALID=1 → both drop immediately (asynchronous). After release, AWREADY=WREADY=ARREADY=1 and a new write/read pair completes normally.
